// File: rtl/pulse_period_monitor_pkg.sv
// Shared types and helpers for the pulse period monitor.
//   mon_state_t : monitor FSM states
//   ERR_CNT_W   : width of the miss/extra statistics counters
//   sat_inc     : increment that sticks at all-ones
package glitch_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, ACQUIRE, LOCKED} mon_state_t;

  localparam int unsigned ERR_CNT_W = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pulse_period_monitor_if.sv
// Signal bundle between the trigger-pulse source/firmware side and the monitor.
//   master : drives pulse_in/enable/clear, observes the measurement/status outputs
//   slave  : the monitor itself
interface pulse_period_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  import glitch_pkg::*;

  logic                 pulse_in;
  logic                 enable;
  logic                 clear;
  logic [CNT_W-1:0]     period_out;
  logic                 period_valid;
  logic                 locked;
  logic                 err;
  logic [ERR_CNT_W-1:0] miss_cnt;
  logic [ERR_CNT_W-1:0] extra_cnt;

  modport master (
    output pulse_in, enable, clear,
    input  period_out, period_valid, locked, err, miss_cnt, extra_cnt
  );

  modport slave (
    input  pulse_in, enable, clear,
    output period_out, period_valid, locked, err, miss_cnt, extra_cnt
  );
endinterface

// File: rtl/pulse_period_monitor_timer.sv
// Interval timer for the pulse period monitor.
//   clk_in1, rst_n : clock, async active-low reset
//   run            : 0 forces the interval count to zero
//   pulse_in       : event input
//   period         : iv+1, the spacing of an event occurring this cycle
//   short_ev       : event arrived before the acceptance window
//   good_ev        : event arrived inside the acceptance window
//   timeout        : last acceptable slot passed without an event
module pulse_interval_timer #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned EXP_PERIOD = 5,
  parameter int unsigned TOL        = 0
) (
  input  logic             clk_in1,
  input  logic             rst_n,
  input  logic             run,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic             short_ev,
  output logic             good_ev,
  output logic             timeout
);
  localparam logic [CNT_W-1:0] LO = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI = CNT_W'(EXP_PERIOD + TOL);

  logic [CNT_W-1:0] iv;

  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n)
      iv <= '0;
    else if (!run || pulse_in)
      iv <= '0;
    else if (iv != '1)
      iv <= iv + 1'b1;
  end

  assign period   = iv + 1'b1;
  assign short_ev = pulse_in && (period < LO);
  assign good_ev  = pulse_in && (period >= LO) && (period <= HI);
  assign timeout  = !pulse_in && (period == HI);
endmodule

// File: rtl/pulse_period_monitor.sv
// Pulse period monitor: measures spacing of the periodic trigger pulse,
// declares lock after a run of good periods and counts missed/extra pulses.
//   clk_in1 : single clock, all logic on posedge
//   rst_n   : asynchronous active-low reset
//   mon     : slave side of pulse_period_monitor_if
//             (pulse_in, enable, clear in; period_out, period_valid,
//              locked, err, miss_cnt, extra_cnt out)
module pulse_period_monitor
  import glitch_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned EXP_PERIOD = 5,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                   clk_in1,
  input  logic                   rst_n,
  pulse_period_monitor_if.slave  mon
);
  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

  mon_state_t           state, state_nx;
  logic [GOOD_W-1:0]    good, good_nx;
  logic [CNT_W-1:0]     period_q, period_nx;
  logic                 valid_q, valid_nx;
  logic                 locked_q;
  logic                 err_q, err_nx;
  logic [ERR_CNT_W-1:0] miss_q, miss_nx;
  logic [ERR_CNT_W-1:0] extra_q, extra_nx;

  logic [CNT_W-1:0]     period;
  logic                 short_ev, good_ev, timeout;

  pulse_interval_timer #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (EXP_PERIOD),
    .TOL        (TOL)
  ) u_timer (
    .clk_in1  (clk_in1),
    .rst_n    (rst_n),
    .run      (mon.enable && !mon.clear),
    .pulse_in (mon.pulse_in),
    .period   (period),
    .short_ev (short_ev),
    .good_ev  (good_ev),
    .timeout  (timeout)
  );

  always_comb begin
    state_nx  = state;
    good_nx   = good;
    period_nx = period_q;
    valid_nx  = 1'b0;
    err_nx    = err_q;
    miss_nx   = miss_q;
    extra_nx  = extra_q;

    if (!mon.enable) begin
      state_nx = IDLE;
      good_nx  = '0;
    end else if (mon.clear) begin
      state_nx  = SYNC;
      good_nx   = '0;
      period_nx = '0;
      err_nx    = 1'b0;
      miss_nx   = '0;
      extra_nx  = '0;
    end else begin
      case (state)
        IDLE: state_nx = SYNC;
        SYNC: begin
          if (mon.pulse_in) begin
            state_nx = ACQUIRE;
            good_nx  = '0;
          end
        end
        ACQUIRE, LOCKED: begin
          // Every event here is reported, short ones included.
          if (mon.pulse_in) begin
            period_nx = period;
            valid_nx  = 1'b1;
          end
          if (short_ev) begin
            extra_nx = sat_inc(extra_q);
            good_nx  = '0;
            if (state == LOCKED) begin
              err_nx   = 1'b1;
              state_nx = ACQUIRE;
            end
          end else if (good_ev) begin
            if (state == ACQUIRE) begin
              if (good == GOOD_W'(LOCK_COUNT - 1)) begin
                state_nx = LOCKED;
                good_nx  = '0;
              end else begin
                good_nx = good + 1'b1;
              end
            end
          end else if (timeout) begin
            miss_nx  = sat_inc(miss_q);
            good_nx  = '0;
            state_nx = SYNC;
            if (state == LOCKED)
              err_nx = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      good     <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      miss_q   <= '0;
      extra_q  <= '0;
    end else begin
      state    <= state_nx;
      good     <= good_nx;
      period_q <= period_nx;
      valid_q  <= valid_nx;
      locked_q <= (state_nx == LOCKED);
      err_q    <= err_nx;
      miss_q   <= miss_nx;
      extra_q  <= extra_nx;
    end
  end

  assign mon.period_out   = period_q;
  assign mon.period_valid = valid_q;
  assign mon.locked       = locked_q;
  assign mon.err          = err_q;
  assign mon.miss_cnt     = miss_q;
  assign mon.extra_cnt    = extra_q;
endmodule
